// File: rtl/nlx_sram_rsp.sv
// Byte-lane SRAM responder with per-word written flags, out-of-range reporting and
// saturating access counters. Define NLX_SRAM_RSP_PIPE_EN for a second read-data stage.
module nlx_sram_rsp #(
  parameter int          DEPTH    = 1024,
  parameter logic [31:0] OOR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  we,
  input  logic [15:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        oor_err,
  input  logic        clr_cnt,
  output logic [15:0] wr_cnt,
  output logic [15:0] rd_cnt
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  logic [31:0]    mem [DEPTH];
  logic [DEPTH-1:0] written;

  logic          in_range;
  logic          is_wr;
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;
  logic [31:0]   rdata_q1;
  logic          oor_q1;

  assign in_range = ({1'b0, addr} < DEPTH_L);
  assign is_wr    = |we;
  assign idx      = addr[AW-1:0];
  assign rd_word  = written[idx] ? mem[idx] : 32'h0;

  // Array is never reset; a first write to a word also zeroes its non-enabled lanes
  // so stale contents from before the flag was cleared never become visible.
  always_ff @(posedge clk) begin
    if (rstn && is_wr && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i] || !written[idx])
          mem[idx][8*i +: 8] <= we[i] ? wdata[8*i +: 8] : 8'h00;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      written  <= '0;
      rdata_q1 <= 32'h0;
      oor_q1   <= 1'b0;
      wr_cnt   <= 16'h0;
      rd_cnt   <= 16'h0;
    end else begin
      oor_q1 <= !in_range;
      if (is_wr) begin
        if (in_range) written[idx] <= 1'b1;
      end else begin
        rdata_q1 <= in_range ? rd_word : OOR_DATA;
      end
      if (clr_cnt) begin
        wr_cnt <= 16'h0;
        rd_cnt <= 16'h0;
      end else if (in_range) begin
        if (is_wr && wr_cnt != 16'hFFFF)  wr_cnt <= wr_cnt + 16'd1;
        if (!is_wr && rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
      end
    end
  end

`ifdef NLX_SRAM_RSP_PIPE_EN
  logic [31:0] rdata_q2;
  logic        oor_q2;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata_q2 <= 32'h0;
      oor_q2   <= 1'b0;
    end else begin
      rdata_q2 <= rdata_q1;
      oor_q2   <= oor_q1;
    end
  end

  assign rdata   = rdata_q2;
  assign oor_err = oor_q2;
`else
  assign rdata   = rdata_q1;
  assign oor_err = oor_q1;
`endif

endmodule

// File: tb/tb_nlx_sram_rsp.sv
// Directed bench for nlx_sram_rsp (DEPTH=1024); read latency follows NLX_SRAM_RSP_PIPE_EN.
module tb_nlx_sram_rsp;
`ifdef NLX_SRAM_RSP_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [3:0]  we = 4'h0;
  logic [15:0] addr = 16'h0;
  logic [31:0] wdata = 32'h0;
  logic        clr_cnt = 1'b0;
  logic [31:0] rdata;
  logic        oor_err;
  logic [15:0] wr_cnt;
  logic [15:0] rd_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_wr   = 0;
  int exp_rd   = 0;

  nlx_sram_rsp #(.DEPTH(1024), .OOR_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .rstn(rstn), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .oor_err(oor_err), .clr_cnt(clr_cnt),
    .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
  );

  always #5 clk = ~clk;

  // One access per edge; expected counters tracked alongside.
  task automatic acc(input logic [3:0] w, input logic [15:0] a, input logic [31:0] d,
                     input logic clr);
    we = w; addr = a; wdata = d; clr_cnt = clr;
    @(posedge clk); #1;
    if (clr) begin
      exp_wr = 0; exp_rd = 0;
    end else if (a < 16'd1024) begin
      if (w != 4'h0) begin
        if (exp_wr < 65535) exp_wr++;
      end else if (exp_rd < 65535) exp_rd++;
    end
    clr_cnt = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a);
    acc(4'h0, a, 32'h0, 1'b0);
    if (LAT == 2) acc(4'h0, a, 32'h0, 1'b0);
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    we = 4'hF; addr = 16'd7; wdata = 32'h5555_5555;
    @(posedge clk); @(posedge clk); #1;
    we = 4'h0; addr = 16'h0;
    rstn = 1'b1;
    exp_wr = 0; exp_rd = 0;
  endtask

  task automatic test_reset();
    #1 rstn = 1'b0;
    #2;
    n_checks++; if (rdata !== 32'h0)   begin n_fail++; $display("FAIL reset_rdata got %h want 0", rdata); end
    n_checks++; if (oor_err !== 1'b0)  begin n_fail++; $display("FAIL reset_oor got %b want 0", oor_err); end
    n_checks++; if (wr_cnt !== 16'h0)  begin n_fail++; $display("FAIL reset_wr_cnt got %h want 0", wr_cnt); end
    n_checks++; if (rd_cnt !== 16'h0)  begin n_fail++; $display("FAIL reset_rd_cnt got %h want 0", rd_cnt); end
    @(posedge clk); #1;
    rstn = 1'b1;
    exp_wr = 0; exp_rd = 0;
  endtask

  task automatic test_read_unwritten();
    rd(16'h0005);
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL unwritten_rdata got %h want 0", rdata); end
    n_checks++; if (rd_cnt !== 16'(LAT)) begin n_fail++; $display("FAIL unwritten_rd_cnt got %0d want %0d", rd_cnt, LAT); end
    n_checks++; if (oor_err !== 1'b0) begin n_fail++; $display("FAIL unwritten_oor got %b want 0", oor_err); end
  endtask

  task automatic test_byte_lanes();
    acc(4'hF, 16'd3, 32'h1234_5678, 1'b0);
    acc(4'b0101, 16'd3, 32'hAABB_CCDD, 1'b0);
    rd(16'd3);
    n_checks++; if (rdata !== 32'h12BB_56DD) begin n_fail++; $display("FAIL byte_lanes got %h want 12bb56dd", rdata); end
    n_checks++; if (wr_cnt !== 16'(exp_wr)) begin n_fail++; $display("FAIL byte_lanes_wr_cnt got %0d want %0d", wr_cnt, exp_wr); end
  endtask

  task automatic test_write_holds();
    acc(4'hF, 16'd3, 32'h0000_0000, 1'b0);
    n_checks++; if (rdata !== 32'h12BB_56DD) begin n_fail++; $display("FAIL hold_on_write got %h want 12bb56dd", rdata); end
    acc(4'hF, 16'h0400, 32'hFFFF_FFFF, 1'b0);
    n_checks++; if (rdata !== 32'h12BB_56DD) begin n_fail++; $display("FAIL hold_on_oor_write got %h want 12bb56dd", rdata); end
    rd(16'd3);
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL hold_new_data got %h want 0", rdata); end
  endtask

  task automatic test_partial_unwritten();
    apply_reset();
    acc(4'b0010, 16'd3, 32'h1122_3344, 1'b0);
    rd(16'd3);
    n_checks++; if (rdata !== 32'h0000_3300) begin n_fail++; $display("FAIL partial_unwritten got %h want 00003300", rdata); end
  endtask

  task automatic test_oor();
    logic [3:0]  hist;
    logic [31:0] oor_rd;
    logic [3:0]  exp_hist;
    exp_hist = (LAT == 1) ? 4'b0011 : 4'b0110;
    oor_rd = 32'h0;
    apply_reset();
    acc(4'hF, 16'd0, 32'h0102_0304, 1'b0);
    acc(4'hF, 16'h0400, 32'hFFFF_FFFF, 1'b0); hist[0] = oor_err;
    acc(4'h0, 16'h0400, 32'h0, 1'b0);         hist[1] = oor_err;
    if (LAT == 1) oor_rd = rdata;
    n_checks++; if (wr_cnt !== 16'd1) begin n_fail++; $display("FAIL oor_wr_cnt got %0d want 1", wr_cnt); end
    n_checks++; if (rd_cnt !== 16'd0) begin n_fail++; $display("FAIL oor_rd_cnt got %0d want 0", rd_cnt); end
    acc(4'h0, 16'd0, 32'h0, 1'b0);            hist[2] = oor_err;
    if (LAT == 2) oor_rd = rdata;
    acc(4'h0, 16'd0, 32'h0, 1'b0);            hist[3] = oor_err;
    n_checks++; if (hist !== exp_hist) begin n_fail++; $display("FAIL oor_pulse got %b want %b", hist, exp_hist); end
    n_checks++; if (oor_rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL oor_rdata got %h want deadbeef", oor_rd); end
    n_checks++; if (rdata !== 32'h0102_0304) begin n_fail++; $display("FAIL oor_write_dropped got %h want 01020304", rdata); end
  endtask

  task automatic test_saturate();
    apply_reset();
    for (int i = 0; i < 65535; i++) acc(4'h0, 16'd1, 32'h0, 1'b0);
    n_checks++; if (rd_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach got %h want ffff", rd_cnt); end
    for (int i = 0; i < 5; i++) acc(4'h0, 16'd1, 32'h0, 1'b0);
    n_checks++; if (rd_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got %h want ffff", rd_cnt); end
    n_checks++; if (wr_cnt !== 16'h0) begin n_fail++; $display("FAIL sat_wr_cnt got %h want 0", wr_cnt); end
    acc(4'hF, 16'd1, 32'h0, 1'b1);
    acc(4'h0, 16'd5, 32'h0, 1'b1);
    n_checks++; if (rd_cnt !== 16'h0) begin n_fail++; $display("FAIL clr_rd_cnt got %h want 0", rd_cnt); end
    n_checks++; if (wr_cnt !== 16'h0) begin n_fail++; $display("FAIL clr_wr_cnt got %h want 0", wr_cnt); end
    acc(4'h0, 16'd5, 32'h0, 1'b0);
    n_checks++; if (rd_cnt !== 16'd1) begin n_fail++; $display("FAIL post_clr_rd_cnt got %h want 1", rd_cnt); end
  endtask

  task automatic test_reset_mid();
    acc(4'hF, 16'd7, 32'hCAFE_F00D, 1'b0);
    rd(16'd7);
    n_checks++; if (rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL mid_pre got %h want cafef00d", rdata); end
    rstn = 1'b0;
    #1;
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL mid_async_rdata got %h want 0", rdata); end
    n_checks++; if (rd_cnt !== 16'h0) begin n_fail++; $display("FAIL mid_async_rd_cnt got %h want 0", rd_cnt); end
    we = 4'hF; addr = 16'd7; wdata = 32'h7777_7777;
    @(posedge clk); #1;
    rstn = 1'b1;
    exp_wr = 0; exp_rd = 0;
    rd(16'd7);
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL mid_after got %h want 0", rdata); end
    n_checks++; if (rd_cnt !== 16'(exp_rd)) begin n_fail++; $display("FAIL mid_rd_cnt got %0d want %0d", rd_cnt, exp_rd); end
    n_checks++; if (wr_cnt !== 16'h0) begin n_fail++; $display("FAIL mid_wr_cnt got %0d want 0", wr_cnt); end
  endtask

  task automatic test_back_to_back();
    acc(4'hF, 16'd9, 32'h0000_0001, 1'b0);
    rd(16'd9);
    n_checks++; if (rdata !== 32'h0000_0001) begin n_fail++; $display("FAIL b2b_first got %h want 1", rdata); end
    acc(4'hF, 16'd9, 32'h0000_0002, 1'b0);
    rd(16'd9);
    n_checks++; if (rdata !== 32'h0000_0002) begin n_fail++; $display("FAIL b2b_second got %h want 2", rdata); end
    n_checks++; if (wr_cnt !== 16'(exp_wr)) begin n_fail++; $display("FAIL b2b_wr_cnt got %0d want %0d", wr_cnt, exp_wr); end
  endtask

  initial begin
    test_reset();
    test_read_unwritten();
    test_byte_lanes();
    test_write_holds();
    test_partial_unwritten();
    test_oor();
    test_reset_mid();
    test_back_to_back();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
